// File: rtl/fpu_norm_seq.sv
// fpu_norm_seq -- multi-cycle normalization sequencer for the FPU mantissa path.
//
// Accepts an unnormalized mantissa and biased exponent. The mantissa is then
// left-justified so that its leading one sits at bit WIDTH-1, and the exponent
// is reduced by the shift distance. If the full shift would take the exponent
// below zero, the shift is clamped to the exponent and the result is flagged
// as denormal (out_uflow). A zero mantissa produces a zero result with
// out_zero set. There is one transaction in flight at a time:
// IDLE -> DETECT -> SHIFT -> DONE.
//
// Optional build macro:
//   FPU_NORM_BYPASS_EN  an input whose mantissa is already normalized
//                       (bit WIDTH-1 set) skips DETECT/SHIFT and goes
//                       straight to DONE, giving one-cycle latency.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   input request          in_ready   block can accept (IDLE)
//   in_mant    unnormalized mantissa  in_exp     biased exponent
//   out_valid  result available       out_ready  consumer accepts
//   out_mant   normalized mantissa    out_exp    adjusted exponent
//   out_zero   input mantissa was zero
//   out_uflow  shift clamped by the exponent (denormal result)

module fpu_pri_encoder #(
  parameter int WIDTH_LOG = 7
) (
  input  logic [(1<<WIDTH_LOG)-1:0] in_vec,
  output logic [WIDTH_LOG-1:0]      msb
);
  // Index of the highest set bit. The result is 0 for an all-zero input,
  // so a caller must resolve zero separately.
  always_comb begin
    msb = '0;
    for (int i = 0; i < (1 << WIDTH_LOG); i++) begin
      if (in_vec[i]) msb = WIDTH_LOG'(i);
    end
  end
endmodule

module fpu_norm_seq #(
  parameter int WIDTH     = 106,
  parameter int WIDTH_LOG = 7,
  parameter int EXP_W     = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_mant,
  input  logic [EXP_W-1:0] in_exp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_mant,
  output logic [EXP_W-1:0] out_exp,
  output logic             out_zero,
  output logic             out_uflow
);
  localparam int ENC_W = 1 << WIDTH_LOG;
  localparam int SH_W  = WIDTH_LOG + 1;
  localparam int CMP_W = (EXP_W > SH_W) ? EXP_W : SH_W;
  localparam logic [SH_W-1:0] TOP_IDX = SH_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, DETECT, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] m_r;
  logic [EXP_W-1:0] e_r;
  logic             z_r;
  logic [SH_W-1:0]  shamt;
  logic [ENC_W-1:0] enc_in;
  logic [WIDTH_LOG-1:0] msb;
  logic [CMP_W-1:0] e_x, s_x, diff;
  logic             clamp;
  logic             bypass_hit;

`ifdef FPU_NORM_BYPASS_EN
  assign bypass_hit = in_mant[WIDTH-1];
`else
  assign bypass_hit = 1'b0;
`endif

  // Encoder sees the held mantissa zero-extended to the encoder width.
  always_comb begin
    enc_in = '0;
    enc_in[WIDTH-1:0] = m_r;
  end

  fpu_pri_encoder #(.WIDTH_LOG(WIDTH_LOG)) u_enc (
    .in_vec (enc_in),
    .msb    (msb)
  );

  // Compare and subtract in a common width so neither operand is truncated;
  // the clamp ensures diff never wraps when it is used.
  always_comb begin
    e_x   = CMP_W'(e_r);
    s_x   = CMP_W'(shamt);
    clamp = s_x > e_x;
    diff  = e_x - s_x;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = bypass_hit ? DONE : DETECT;
      end
      DETECT: state_nxt = SHIFT;
      SHIFT:  state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are written only on the way into DONE, so they stay stable
  // for as long as the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_r       <= '0;
      e_r       <= '0;
      z_r       <= 1'b0;
      shamt     <= '0;
      out_mant  <= '0;
      out_exp   <= '0;
      out_zero  <= 1'b0;
      out_uflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            m_r <= in_mant;
            e_r <= in_exp;
            z_r <= ~|in_mant;
            if (bypass_hit) begin
              out_mant  <= in_mant;
              out_exp   <= in_exp;
              out_zero  <= 1'b0;
              out_uflow <= 1'b0;
            end
          end
        end
        DETECT: shamt <= TOP_IDX - SH_W'(msb);
        SHIFT: begin
          if (z_r) begin
            out_mant  <= '0;
            out_exp   <= '0;
            out_zero  <= 1'b1;
            out_uflow <= 1'b0;
          end else if (clamp) begin
            out_mant  <= m_r << e_r;
            out_exp   <= '0;
            out_zero  <= 1'b0;
            out_uflow <= 1'b1;
          end else begin
            out_mant  <= m_r << shamt;
            out_exp   <= diff[EXP_W-1:0];
            out_zero  <= 1'b0;
            out_uflow <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_norm_seq.sv
// Directed testbench for fpu_norm_seq with hand-computed expected values.
module tb_fpu_norm_seq;
  localparam int WIDTH = 106;
  localparam int EXP_W = 12;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_mant;
  logic [EXP_W-1:0] in_exp;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_mant;
  logic [EXP_W-1:0] out_exp;
  logic             out_zero;
  logic             out_uflow;

  int vectors = 0;
  int miscompares = 0;

  fpu_norm_seq #(.WIDTH(WIDTH), .WIDTH_LOG(7), .EXP_W(EXP_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mant   (in_mant),
    .in_exp    (in_exp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mant  (out_mant),
    .out_exp   (out_exp),
    .out_zero  (out_zero),
    .out_uflow (out_uflow)
  );

  always #5 clk = ~clk;

`ifdef FPU_NORM_BYPASS_EN
  localparam int BYP_LAT = 1;
`else
  localparam int BYP_LAT = 3;
`endif

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one input, measure latency to out_valid and check the result.
  // Returns with the block in DONE (out_valid high) and the clock just past an edge.
  task automatic start_wait(input string tag, input logic [WIDTH-1:0] m,
                            input logic [EXP_W-1:0] e, input int exp_lat);
    int lat;
    in_valid = 1'b1;
    in_mant  = m;
    in_exp   = e;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
  endtask

  task automatic check_out(input string tag, input logic [WIDTH-1:0] xm,
                           input logic [EXP_W-1:0] xe, input logic xz, input logic xu);
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_mant"},  out_mant,  xm);
    chk({tag, "_exp"},   out_exp,   xe);
    chk({tag, "_zero"},  out_zero,  xz);
    chk({tag, "_uflow"}, out_uflow, xu);
  endtask

  task automatic run(input string tag, input logic [WIDTH-1:0] m, input logic [EXP_W-1:0] e,
                     input int exp_lat, input logic [WIDTH-1:0] xm,
                     input logic [EXP_W-1:0] xe, input logic xz, input logic xu);
    start_wait(tag, m, e, exp_lat);
    check_out(tag, xm, xe, xz, xu);
    tick();  // out_ready is high: output handshake on this edge
    chk({tag, "_ready_after"}, in_ready, 1'b1);
    chk({tag, "_valid_after"}, out_valid, 1'b0);
  endtask

  logic [WIDTH-1:0] one;
  logic [WIDTH-1:0] hold_m;
  logic [EXP_W-1:0] hold_e;

  initial begin
    one       = {{(WIDTH-1){1'b0}}, 1'b1};
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mant   = '0;
    in_exp    = '0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst_in_ready",  in_ready,  1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_mant",  out_mant,  '0);
    chk("rst_out_exp",   out_exp,   '0);
    chk("rst_out_zero",  out_zero,  1'b0);
    chk("rst_out_uflow", out_uflow, 1'b0);
    rst_n = 1'b1;
    tick();

    // Basic normalize: shift 5
    run("norm", one << 100, 12'd50, 3, one << 105, 12'd45, 1'b0, 1'b0);
    // Zero mantissa
    run("zero", '0, 12'd77, 3, '0, 12'd0, 1'b1, 1'b0);
    // Needs 105 but exponent only allows 10
    run("uflow", one, 12'd10, 3, one << 10, 12'd0, 1'b0, 1'b1);
    // Shift exactly equals exponent: not a clamp
    run("edge", one << 95, 12'd10, 3, one << 105, 12'd0, 1'b0, 1'b0);
    // Multi-bit mantissa, leading one at 51 -> shift 54
    run("multi", (one << 51) | (one << 50) | one, 12'd1000, 3,
        (one << 105) | (one << 104) | (one << 54), 12'd946, 1'b0, 1'b0);

    // Backpressure: leading one at 2 -> shift 103, exp 200-103 = 97
    out_ready = 1'b0;
    start_wait("bp", (one << 2) | one, 12'd200, 3);
    hold_m = (one << 105) | (one << 103);
    hold_e = 12'd97;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_mant  = one << 7;
      in_exp   = 12'd5;
      tick();
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_mant", out_mant, hold_m);
      chk("bp_exp", out_exp, hold_e);
      chk("bp_flags", {out_zero, out_uflow}, 2'b00);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release_ready", in_ready, 1'b1);
    chk("bp_release_valid", out_valid, 1'b0);
    tick();
    chk("bp_no_ghost", out_valid, 1'b0);

    // Reset while in SHIFT discards the transaction
    in_valid = 1'b1;
    in_mant  = one;
    in_exp   = 12'd5;
    tick();            // accepted -> DETECT
    in_valid = 1'b0;
    tick();            // -> SHIFT
    rst_n = 1'b0;
    tick();
    chk("rstmid_valid", out_valid, 1'b0);
    chk("rstmid_ready", in_ready, 1'b1);
    chk("rstmid_mant", out_mant, '0);
    rst_n = 1'b1;
    tick();
    chk("rstmid_no_ghost", out_valid, 1'b0);
    run("post_rst", one << 104, 12'd3, 3, one << 105, 12'd2, 1'b0, 1'b0);

    // Already normalized: bypass path when enabled, shift 0 otherwise
    run("bypass", one << 105, 12'd20, BYP_LAT, one << 105, 12'd20, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fpu_norm_seq.md
# fpu_norm_seq

Multi-cycle normalization sequencer for the FPU mantissa path. It accepts an unnormalized mantissa and exponent over a valid/ready handshake. It drives an internal `fpu_pri_encoder` instance to locate the leading one, then left-justifies the mantissa and adjusts the exponent, clamping at exponent 0. It sits between the adder/multiplier mantissa datapaths and the rounding stage.

## Interface
- `WIDTH`, 106: mantissa width.
- `WIDTH_LOG`, 7: encoder index width; `1<<WIDTH_LOG` must be ≥ `WIDTH`.
- `EXP_W`, 12: unsigned biased exponent width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `in_valid` in 1: input request.
- `in_ready` out 1: block can accept.
- `in_mant` in WIDTH: unnormalized mantissa.
- `in_exp` in EXP_W: biased exponent.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer accepts.
- `out_mant` out WIDTH: normalized mantissa.
- `out_exp` out EXP_W: adjusted exponent.
- `out_zero` out 1: input mantissa was zero.
- `out_uflow` out 1: shift was clamped by the exponent (denormal result).

## Operation
- FSM states: IDLE, DETECT, SHIFT, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: register `in_mant` into `m_r`, `in_exp` into `e_r`, and `z_r`=~|`in_mant`. Go to DETECT.
- DETECT:
  - `m_r`, zero-extended to `1<<WIDTH_LOG` bits, drives the encoder.
  - Register `shamt` = WIDTH-1-msb, width WIDTH_LOG+1. Go to SHIFT.
- SHIFT:
  - If `z_r`: `out_mant`=0, `out_exp`=0, `out_zero`=1, `out_uflow`=0.
  - Else if `shamt` > `e_r`: `out_mant`=`m_r`<<`e_r`, `out_exp`=0, `out_uflow`=1.
  - Else: `out_mant`=`m_r`<<`shamt`, `out_exp`=`e_r`-`shamt`, `out_uflow`=0. `shamt`==`e_r` gives `out_exp`=0 with `out_uflow`=0.
  - Go to DONE.
- DONE:
  - `out_valid`=1.
  - All outputs are held stable while `out_ready`=0.
  - On `out_ready`: go to IDLE.
- `in_ready` is 0 in DETECT, SHIFT and DONE. There is no overlap of transactions.
- Encoder msb is ambiguous for zero input and for value 1. Zero is resolved only by `z_r`, never by the encoder output.
- Exponent subtraction is unsigned EXP_W-bit. The clamp guarantees no wrap-around.

## Timing
- Reset values: state=IDLE, `in_ready`=1 (combinational from state), `out_valid`=0, `out_mant`=0, `out_exp`=0, `out_zero`=0, `out_uflow`=0. Internal registers are cleared.
- Latency: input handshake at cycle N gives `out_valid`=1 at cycle N+3.
- Throughput: 1 result per 4 cycles when `out_ready` is held at 1.
- Output handshake at cycle M gives `in_ready`=1 at M+1. A new accept happens no earlier than M+1.
- Reset asserted in any state: the next edge returns to IDLE and `out_valid`=0. The in-flight transaction is discarded and never produced.
- `in_valid` while not in IDLE is ignored, with no state effect. Upstream must hold it.

## Configuration
- `FPU_NORM_BYPASS_EN` defined:
  - In IDLE, an accepted `in_mant` with bit WIDTH-1 set goes directly to DONE.
  - `out_mant`=`in_mant`, `out_exp`=`in_exp`, and the flags are 0.
  - `out_valid` at N+1.
- Undefined: every transaction traverses DETECT and SHIFT with latency N+3.

## Test plan
- Normalize: `in_mant`=1<<100, `in_exp`=50 → at N+3 `out_mant`=1<<105, `out_exp`=45, flags 0.
- Zero: `in_mant`=0, `in_exp`=77 → `out_mant`=0, `out_exp`=0, `out_zero`=1, `out_uflow`=0.
- Underflow clamp: `in_mant`=1, `in_exp`=10 → `out_mant`=1<<10, `out_exp`=0, `out_uflow`=1. Boundary case: `in_mant`=1<<95, `in_exp`=10 → `out_mant`=1<<105, `out_exp`=0, `out_uflow`=0.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE → outputs stable, `in_ready`=0, `in_valid` pulses ignored. Release → `in_ready`=1 next cycle.
- Reset mid-op: deassert `rst_n` in SHIFT → next cycle IDLE, `out_valid`=0. The following transaction (`in_mant`=1<<104, `in_exp`=3) yields `out_mant`=1<<105, `out_exp`=2.
- Bypass, with `FPU_NORM_BYPASS_EN` defined: `in_mant`=1<<105, `in_exp`=20 → `out_valid` at N+1, `out_exp`=20. Without the macro, the same result arrives at N+3.
